// File: rtl/tnn_seq_classifier.sv
// tnn_seq_classifier
//   Sequential ternary-weight classifier. Takes N_FEAT unsigned features, one
//   per accepted cycle, and adds each one into N_HID hidden accumulators using
//   ternary weights. It then thresholds every accumulator into a hidden bit and
//   majority-thresholds the hidden bits into a 1-bit class.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   clear               synchronous abort of the current sample (highest priority)
//   in_valid/in_ready   feature handshake; in_feat is the unsigned feature value
//   out_valid/out_ready result handshake
//   out_class           class decision
//   out_hid             registered hidden-neuron bits
//
// Flow: LOAD (accept features) -> EVAL (register decision, 1 cycle) ->
//       HOLD (present result until taken) -> LOAD.

// One hidden neuron: a signed accumulator driven by a ternary weight.
module tnn_seq_neuron #(
    parameter int FEAT_W = 2,
    parameter int ACC_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     zero,
    input  logic                     acc_en,
    input  logic [1:0]               w,
    input  logic [FEAT_W-1:0]        feat,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [ACC_W-1:0] term;

    // Zero-extend the unsigned feature into the signed accumulator width.
    assign term = $signed({{(ACC_W-FEAT_W){1'b0}}, feat});

    // Weight code 01 = +1 and 11 = -1. Codes 00 and 10 mean 0, so acc holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (zero)
            acc <= '0;
        else if (acc_en && w == 2'b01)
            acc <= acc + term;
        else if (acc_en && w == 2'b11)
            acc <= acc - term;
    end
endmodule

module tnn_seq_classifier #(
    parameter int                         N_FEAT  = 9,
    parameter int                         FEAT_W  = 2,
    parameter int                         N_HID   = 4,
    parameter logic [2*N_HID*N_FEAT-1:0]  W_HID   = '0,
    parameter int                         HID_THR = 1,
    parameter int                         OUT_THR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FEAT_W-1:0] in_feat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_class,
    output logic [N_HID-1:0]  out_hid
);
    // Worst-case magnitude N_FEAT*(2^FEAT_W-1) plus a sign bit, so no saturation.
    localparam int ACC_W = $clog2(N_FEAT*(2**FEAT_W-1)+1) + 1;
    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    typedef enum logic [1:0] {LOAD, EVAL, HOLD} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        feat_idx;
    logic                    accept, last_feat, zero_acc;
    logic [N_HID-1:0]        hid_nxt;
    logic                    class_nxt;
    logic signed [ACC_W-1:0] acc [N_HID];

    // clear drops any feature offered in the same cycle.
    assign accept    = in_valid && in_ready && !clear;
    assign last_feat = (feat_idx == IDX_W'(N_FEAT-1));
    // Accumulators are zeroed on abort, and on the result handshake so that
    // the next sample starts from zero.
    assign zero_acc  = clear || (state == HOLD && out_ready);

    // ---------------- hidden neurons ----------------
    for (genvar h = 0; h < N_HID; h++) begin : g_hid
        logic [N_FEAT-1:0][1:0] w_row;
        assign w_row = W_HID[2*h*N_FEAT +: 2*N_FEAT];

        tnn_seq_neuron #(.FEAT_W(FEAT_W), .ACC_W(ACC_W)) u_neuron (
            .clk    (clk),
            .rst    (rst),
            .zero   (zero_acc),
            .acc_en (accept),
            .w      (w_row[feat_idx]),
            .feat   (in_feat),
            .acc    (acc[h])
        );

        assign hid_nxt[h] = (int'(acc[h]) >= HID_THR);
    end

    // Majority stage: popcount of the hidden bits against OUT_THR.
    always_comb begin
        int pc;
        pc = 0;
        for (int h = 0; h < N_HID; h++)
            pc = pc + int'(hid_nxt[h]);
        class_nxt = (pc >= OUT_THR);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (accept && last_feat) state_nxt = EVAL;
            end
            EVAL: state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
        if (clear) state_nxt = LOAD;
    end

    // Feature index wraps after the last feature of a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            feat_idx <= '0;
        else if (clear)
            feat_idx <= '0;
        else if (accept)
            feat_idx <= last_feat ? '0 : feat_idx + 1'b1;
    end

    // The result is registered in EVAL. It holds until the next EVAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_hid   <= '0;
            out_class <= 1'b0;
        end else if (state == EVAL) begin
            out_hid   <= hid_nxt;
            out_class <= class_nxt;
        end
    end
endmodule
